// File: rtl/dvi_tmds_encoder.sv
// dvi_tmds_encoder
//   DVI 1.0 TMDS 8b/10b encoder for three colour channels (B, G, R).
//   Two register stages per channel:
//     stage 1: transition-minimising q_m word plus de / control bits
//     stage 2: DC-balancing against a running disparity, or a control token
//   Optional frame monitor compiled in with `define DVI_TIMING_MON_EN.
// Parameters:
//   HSYNC_INV / VSYNC_INV : 1 inverts the corresponding sync before use
// Ports:
//   clk_in, rst_in        : pixel clock, synchronous active-high reset
//   vsync_in, hsync_in    : syncs from the timing generator
//   de_in                 : data enable (active pixels)
//   red_in/green_in/blue_in : 8-bit pixel data
//   tmds_r/g/b_out        : 10-bit TMDS symbols, bit 0 first on the wire
//   active_width_out      : de-high cycles of last line of previous frame
//   active_lines_out      : active lines in previous frame
module dvi_tmds_encoder #(
    parameter bit HSYNC_INV = 1'b0,
    parameter bit VSYNC_INV = 1'b0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        vsync_in,
    input  logic        hsync_in,
    input  logic        de_in,
    input  logic [7:0]  red_in,
    input  logic [7:0]  green_in,
    input  logic [7:0]  blue_in,
    output logic [9:0]  tmds_r_out,
    output logic [9:0]  tmds_g_out,
    output logic [9:0]  tmds_b_out,
    output logic [11:0] active_width_out,
    output logic [11:0] active_lines_out
);
    localparam int unsigned DW = 8;
    localparam int unsigned QW = 9;
    localparam int unsigned SW = 10;
    localparam int unsigned CW = 5;
    localparam int unsigned MW = 12;

    localparam logic [SW-1:0]        TOKEN_00 = 10'b1101010100;
    localparam logic signed [CW-1:0] TWO      = 5'sd2;
    localparam logic signed [CW-1:0] ZERO     = 5'sd0;

    // Stage 1: transition-minimised word
    function automatic logic [QW-1:0] minimise_transitions(input logic [DW-1:0] d);
        logic [3:0]    n1d;
        logic          use_xnor;
        logic [QW-1:0] qm;
        n1d      = 4'($countones(d));
        use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d[0]);
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < int'(DW); i++)
            qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[DW]   = ~use_xnor;
        return qm;
    endfunction

    // Control token for c1c0
    function automatic logic [SW-1:0] control_token(input logic [1:0] c);
        logic [SW-1:0] t;
        case (c)
            2'b00:   t = 10'b1101010100;
            2'b01:   t = 10'b0010101011;
            2'b10:   t = 10'b0101010100;
            default: t = 10'b1010101011;
        endcase
        return t;
    endfunction

    logic          vsync_pol, hsync_pol;
    logic          de_s1, vsync_s1, hsync_s1;
    logic [DW-1:0] pix [3];

    assign vsync_pol = vsync_in ^ VSYNC_INV;
    assign hsync_pol = hsync_in ^ HSYNC_INV;
    assign pix[0]    = blue_in;
    assign pix[1]    = green_in;
    assign pix[2]    = red_in;

    // Stage-1 de and sync registers shared by all channels
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            de_s1    <= 1'b0;
            vsync_s1 <= 1'b0;
            hsync_s1 <= 1'b0;
        end else begin
            de_s1    <= de_in;
            vsync_s1 <= vsync_pol;
            hsync_s1 <= hsync_pol;
        end
    end

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic [QW-1:0]        qm_s1;
        logic [1:0]           ctl_s1;
        logic [3:0]           n1q;
        logic                 q8, cnt_pos, cnt_neg, bal_pos, bal_neg;
        logic signed [CW-1:0] bal, cnt_q, cnt_d;
        logic [SW-1:0]        sym_q, sym_d;

        // Only the blue channel carries hsync/vsync
        assign ctl_s1 = (ch == 0) ? {vsync_s1, hsync_s1} : 2'b00;

        always_ff @(posedge clk_in) begin
            if (rst_in) qm_s1 <= '0;
            else        qm_s1 <= minimise_transitions(pix[ch]);
        end

        // Stage 2: pick inversion that pulls running disparity toward zero
        always_comb begin
            q8      = qm_s1[DW];
            n1q     = 4'($countones(qm_s1[DW-1:0]));
            bal     = $signed({n1q, 1'b0} - 5'd8);   // ones minus zeros
            cnt_neg = cnt_q[CW-1];
            cnt_pos = !cnt_q[CW-1] && (cnt_q != ZERO);
            bal_neg = bal[CW-1];
            bal_pos = !bal[CW-1] && (bal != ZERO);
            sym_d   = control_token(ctl_s1);
            cnt_d   = ZERO;
            if (de_s1) begin
                if ((cnt_q == ZERO) || (bal == ZERO)) begin
                    sym_d = {~q8, q8, q8 ? qm_s1[DW-1:0] : ~qm_s1[DW-1:0]};
                    cnt_d = q8 ? (cnt_q + bal) : (cnt_q - bal);
                end else if ((cnt_pos && bal_pos) || (cnt_neg && bal_neg)) begin
                    sym_d = {1'b1, q8, ~qm_s1[DW-1:0]};
                    cnt_d = cnt_q - bal + (q8 ? TWO : ZERO);
                end else begin
                    sym_d = {1'b0, q8, qm_s1[DW-1:0]};
                    cnt_d = cnt_q + bal - (q8 ? ZERO : TWO);
                end
            end
        end

        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                sym_q <= TOKEN_00;
                cnt_q <= ZERO;
            end else begin
                sym_q <= sym_d;
                cnt_q <= cnt_d;
            end
        end
    end

    assign tmds_b_out = g_ch[0].sym_q;
    assign tmds_g_out = g_ch[1].sym_q;
    assign tmds_r_out = g_ch[2].sym_q;

`ifdef DVI_TIMING_MON_EN
    logic          de_d, vsync_d, de_rise, de_fall, vsync_rise;
    logic [MW-1:0] x_cnt, y_cnt, width_q, width_o, lines_o;

    assign de_rise    = de_s1 & ~de_d;
    assign de_fall    = ~de_s1 & de_d;
    assign vsync_rise = vsync_s1 & ~vsync_d;

    // Frame monitor; a line ending on the vsync edge is counted before latching
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            de_d    <= 1'b0;
            vsync_d <= 1'b0;
            x_cnt   <= '0;
            y_cnt   <= '0;
            width_q <= '0;
            width_o <= '0;
            lines_o <= '0;
        end else begin
            de_d    <= de_s1;
            vsync_d <= vsync_s1;
            if (de_rise)    x_cnt <= MW'(1);
            else if (de_s1) x_cnt <= x_cnt + MW'(1);
            if (de_fall)    width_q <= x_cnt;
            if (vsync_rise) begin
                width_o <= de_fall ? x_cnt : width_q;
                lines_o <= de_fall ? (y_cnt + MW'(1)) : y_cnt;
                y_cnt   <= '0;
            end else if (de_fall) begin
                y_cnt   <= y_cnt + MW'(1);
            end
        end
    end

    assign active_width_out = width_o;
    assign active_lines_out = lines_o;
`else
    assign active_width_out = MW'(0);
    assign active_lines_out = MW'(0);
`endif

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// tb_dvi_tmds_encoder
//   Scoreboard bench: the driver pushes the expected symbols for every
//   sampled input set; a monitor pops one entry per clock and compares.
//   Two instances: plain polarity and both syncs inverted.
module tb_dvi_tmds_encoder;
    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;
    localparam int LINE_W = 6;
    localparam int NLINES = 4;

    typedef struct packed {
        int unsigned     tag;
        logic [2:0][9:0] e0;
        logic [2:0][9:0] e1;
        logic            lit_en;
        logic [9:0]      lit0;
        logic [9:0]      lit1;
    } item_t;

    logic clk = 1'b0;
    logic rst, vsync, hsync, de;
    logic [7:0] red, green, blue;
    logic [9:0] o0_r, o0_g, o0_b, o1_r, o1_g, o1_b;
    logic [11:0] aw0, al0, aw1, al1;

    item_t       sbq[$];
    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int          m0[3];
    int          m1[3];

    always #5 clk = ~clk;

    dvi_tmds_encoder #(.HSYNC_INV(1'b0), .VSYNC_INV(1'b0)) dut0 (
        .clk_in(clk), .rst_in(rst), .vsync_in(vsync), .hsync_in(hsync), .de_in(de),
        .red_in(red), .green_in(green), .blue_in(blue),
        .tmds_r_out(o0_r), .tmds_g_out(o0_g), .tmds_b_out(o0_b),
        .active_width_out(aw0), .active_lines_out(al0));

    dvi_tmds_encoder #(.HSYNC_INV(1'b1), .VSYNC_INV(1'b1)) dut1 (
        .clk_in(clk), .rst_in(rst), .vsync_in(vsync), .hsync_in(hsync), .de_in(de),
        .red_in(red), .green_in(green), .blue_in(blue),
        .tmds_r_out(o1_r), .tmds_g_out(o1_g), .tmds_b_out(o1_b),
        .active_width_out(aw1), .active_lines_out(al1));

    function automatic logic [9:0] token(input logic [1:0] c);
        logic [9:0] t;
        case (c)
            2'b00:   t = TOK00;
            2'b01:   t = TOK01;
            2'b10:   t = TOK10;
            default: t = TOK11;
        endcase
        return t;
    endfunction

    // Reference: build q_m, choose inversion by sign of disparity vs word balance,
    // and advance disparity by the ones-minus-zeros of the transmitted word.
    function automatic logic [9:0] ref_data(input logic [7:0] d, input int cnt_in,
                                            output int cnt_out);
        int         n1d, bal;
        logic       use_xnor, inv;
        logic [8:0] qm;
        logic [9:0] w;
        n1d      = $countones(d);
        use_xnor = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        qm       = '0;
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = use_xnor ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !use_xnor;
        bal   = 2 * $countones(qm[7:0]) - 8;
        if (cnt_in == 0 || bal == 0) inv = ~qm[8];
        else                         inv = ((cnt_in > 0) == (bal > 0));
        w       = {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
        cnt_out = cnt_in + 2 * $countones(w) - 10;
        return w;
    endfunction

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input logic r_, input logic de_, input logic vs_, input logic hs_,
                         input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb,
                         input logic le, input logic [9:0] l0, input logic [9:0] l1);
        item_t      it;
        logic [7:0] px [3];
        logic [1:0] c0, c1;
        int         nc;
        @(negedge clk);
        rst = r_; de = de_; vsync = vs_; hsync = hs_;
        red = rr; green = gg; blue = bb;
        px[0] = bb; px[1] = gg; px[2] = rr;
        it = '0;
        it.tag = cyc + 1;
        it.lit_en = le; it.lit0 = l0; it.lit1 = l1;
        for (int ch = 0; ch < 3; ch++) begin
            c0 = (ch == 0) ? {vs_, hs_} : 2'b00;
            c1 = (ch == 0) ? {~vs_, ~hs_} : 2'b00;
            if (r_) begin
                it.e0[ch] = TOK00; it.e1[ch] = TOK00; m0[ch] = 0; m1[ch] = 0;
            end else if (!de_) begin
                it.e0[ch] = token(c0); it.e1[ch] = token(c1); m0[ch] = 0; m1[ch] = 0;
            end else begin
                it.e0[ch] = ref_data(px[ch], m0[ch], nc); m0[ch] = nc;
                it.e1[ch] = ref_data(px[ch], m1[ch], nc); m1[ch] = nc;
            end
        end
        sbq.push_back(it);
    endtask

    task automatic do_reset(input int n);
        repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, '0, '0);
    endtask

    task automatic ctl(input logic vs_, input logic hs_, input logic le,
                       input logic [9:0] l0, input logic [9:0] l1);
        drive(1'b0, 1'b0, vs_, hs_, 8'($urandom), 8'($urandom), 8'($urandom), le, l0, l1);
    endtask

    task automatic pix_b(input logic [7:0] bb, input logic le, input logic [9:0] l);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom), bb, le, l, l);
    endtask

    // Monitor: output after edge M corresponds to inputs sampled at edge M-1
    initial begin : monitor
        item_t it;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            while (sbq.size() > 0 && sbq[0].tag + 1 < cyc) void'(sbq.pop_front());
            if (rst) begin
                chk("rst_b0", 12'(o0_b), 12'(TOK00)); chk("rst_g0", 12'(o0_g), 12'(TOK00));
                chk("rst_r0", 12'(o0_r), 12'(TOK00)); chk("rst_b1", 12'(o1_b), 12'(TOK00));
                chk("rst_g1", 12'(o1_g), 12'(TOK00)); chk("rst_r1", 12'(o1_r), 12'(TOK00));
                if (sbq.size() > 0 && sbq[0].tag + 1 == cyc) void'(sbq.pop_front());
            end else if (sbq.size() > 0 && sbq[0].tag + 1 == cyc) begin
                it = sbq.pop_front();
                chk("b0", 12'(o0_b), 12'(it.e0[0])); chk("g0", 12'(o0_g), 12'(it.e0[1]));
                chk("r0", 12'(o0_r), 12'(it.e0[2])); chk("b1", 12'(o1_b), 12'(it.e1[0]));
                chk("g1", 12'(o1_g), 12'(it.e1[1])); chk("r1", 12'(o1_r), 12'(it.e1[2]));
                if (it.lit_en) begin
                    chk("lit_b0", 12'(o0_b), 12'(it.lit0));
                    chk("lit_b1", 12'(o1_b), 12'(it.lit1));
                end
            end else begin
                total++; bad++;
                $display("FAIL sb_underflow cyc=%0d got=none want=entry", cyc);
            end
        end
    end

    initial begin : stim
        logic       rvs, rhs, cur_de;
        int         run, exp_w, exp_l;
        logic [7:0] rr, gg, bb;
        rst = 1'b1; de = 1'b0; vsync = 1'b0; hsync = 1'b0;
        red = '0; green = '0; blue = '0;
        for (int i = 0; i < 3; i++) begin m0[i] = 0; m1[i] = 0; end

        // Reset and release with syncs low
        do_reset(3);
        ctl(1'b0, 1'b0, 1'b1, TOK00, TOK11);
        ctl(1'b0, 1'b0, 1'b1, TOK00, TOK11);
        chk("mon_w_rst0", aw0, 12'd0); chk("mon_l_rst0", al0, 12'd0);

        // Control tokens with hsync high
        ctl(1'b0, 1'b1, 1'b1, TOK01, TOK10);
        ctl(1'b0, 1'b1, 1'b1, TOK01, TOK10);
        ctl(1'b0, 1'b0, 1'b1, TOK00, TOK11);

        // Disparity walk on blue 0x00
        pix_b(8'h00, 1'b1, 10'b0100000000);
        pix_b(8'h00, 1'b1, 10'b1111111111);
        pix_b(8'h00, 1'b1, 10'b0100000000);
        ctl(1'b0, 1'b0, 1'b1, TOK00, TOK11);

        // XNOR path
        pix_b(8'hFF, 1'b1, 10'b1000000000);
        ctl(1'b0, 1'b0, 1'b1, TOK00, TOK11);

        // de gap clears disparity
        pix_b(8'h00, 1'b1, 10'b0100000000);
        ctl(1'b0, 1'b0, 1'b1, TOK00, TOK11);
        pix_b(8'h00, 1'b1, 10'b0100000000);

        // Mid-line reset discards disparity
        pix_b(8'h00, 1'b0, '0);
        do_reset(1);
        pix_b(8'h00, 1'b1, 10'b0100000000);
        ctl(1'b0, 1'b0, 1'b0, '0, '0);

        // Frame monitor scenario
        do_reset(2);
        repeat (3) ctl(1'b0, 1'b0, 1'b0, '0, '0);
        for (int l = 0; l < NLINES; l++) begin
            repeat (LINE_W) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom), 8'($urandom),
                                  8'($urandom), 1'b0, '0, '0);
            repeat (3) ctl(1'b0, 1'b0, 1'b0, '0, '0);
        end
        repeat (2) ctl(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (5) ctl(1'b0, 1'b0, 1'b0, '0, '0);
`ifdef DVI_TIMING_MON_EN
        exp_w = LINE_W; exp_l = NLINES;
`else
        exp_w = 0; exp_l = 0;
`endif
        chk("mon_w0", aw0, 12'(exp_w)); chk("mon_l0", al0, 12'(exp_l));
        chk("mon_w1", aw1, 12'(exp_w)); chk("mon_l1", al1, 12'(exp_l));

        // Randomised traffic with occasional resets
        rvs = 1'b0; rhs = 1'b0; cur_de = 1'b0; run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                cur_de = ~cur_de;
                run = int'($urandom_range(cur_de ? 40 : 8, 1));
            end
            run--;
            if ($urandom_range(15, 0) == 0) rvs = ~rvs;
            if ($urandom_range(15, 0) == 0) rhs = ~rhs;
            case ($urandom_range(3, 0))
                0:       bb = 8'h00;
                1:       bb = 8'hFF;
                default: bb = 8'($urandom);
            endcase
            rr = 8'($urandom); gg = 8'($urandom);
            drive($urandom_range(299, 0) == 0, cur_de, rvs, rhs, rr, gg, bb, 1'b0, '0, '0);
        end

        repeat (4) ctl(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
